// File: rtl/conv_result_collector.sv
// Collects convolver adder-tree results into a small valid/ready FIFO tagged with feature-map coordinates.
// Optional CONV_RESULT_RELU_EN clamps negative samples to zero before they are queued.
module conv_result_collector #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 5,
   parameter int IMAGE_SIZE  = 28,
   parameter int FIFO_DEPTH  = 4,
   localparam int OUT_SIZE   = IMAGE_SIZE - KERNEL_SIZE + 1,
   localparam int CW         = $clog2(OUT_SIZE)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] result_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] out_data,
   output logic [CW-1:0]                out_row,
   output logic [CW-1:0]                out_col,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow,
   output logic                         stream_err
);

   localparam int PW = $clog2(IMAGE_SIZE);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] LAST_PIX = PW'(IMAGE_SIZE - 1);
   localparam logic [PW-1:0] EDGE     = PW'(KERNEL_SIZE - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

   state_t                       state;
   logic [PW-1:0]                pix_row, pix_col;
   logic [PW-1:0]                row_d, col_d;
   logic                         valid_d;
   logic [AW-1:0]                wr_ptr, rd_ptr;
   logic [NW-1:0]                count;
   logic signed [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
   logic [CW-1:0]                mem_row  [FIFO_DEPTH];
   logic [CW-1:0]                mem_col  [FIFO_DEPTH];
   logic                         frame_start, push, pop, full, push_ok;
   logic signed [DATA_WIDTH-1:0] push_data;

   assign frame_start = (state == IDLE) && start;
   assign push        = valid_d && (row_d >= EDGE) && (col_d >= EDGE);
   assign full        = (count == NW'(FIFO_DEPTH));
   assign pop         = out_valid && out_ready;
   assign push_ok     = push && (!full || pop);

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
   assign out_row   = out_valid ? mem_row[rd_ptr]  : '0;
   assign out_col   = out_valid ? mem_col[rd_ptr]  : '0;

`ifdef CONV_RESULT_RELU_EN
   assign push_data = result_in[DATA_WIDTH-1] ? '0 : result_in;
`else
   assign push_data = result_in;
`endif

   // Frame sequencing; DRAIN waits for the last window sample and an empty FIFO before pulsing done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         pix_row    <= '0;
         pix_col    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         stream_err <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= STREAM;
                  pix_row    <= '0;
                  pix_col    <= '0;
                  stream_err <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            STREAM: begin
               if (!in_valid) begin
                  stream_err <= 1'b1;
                  state      <= IDLE;
                  busy       <= 1'b0;
               end else if (pix_col == LAST_PIX) begin
                  pix_col <= '0;
                  if (pix_row == LAST_PIX) begin
                     pix_row <= '0;
                     state   <= DRAIN;
                  end else begin
                     pix_row <= pix_row + 1'b1;
                  end
               end else begin
                  pix_col <= pix_col + 1'b1;
               end
            end
            DRAIN: begin
               if (!valid_d && !out_valid) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // The adder tree lags the pixel stream by one cycle, so the pixel position is delayed to match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_d <= 1'b0;
         row_d   <= '0;
         col_d   <= '0;
      end else begin
         valid_d <= (state == STREAM) && in_valid;
         row_d   <= pix_row;
         col_d   <= pix_col;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (!push_ok && pop) count <= count - 1'b1;
         if (frame_start)          overflow <= 1'b0;
         else if (push && !push_ok) overflow <= 1'b1;
      end
   end

   // Storage is left unreset; the head is masked by out_valid so stale entries never appear.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_data[wr_ptr] <= push_data;
         mem_row[wr_ptr]  <= CW'(row_d - EDGE);
         mem_col[wr_ptr]  <= CW'(col_d - EDGE);
      end
   end

endmodule

// File: doc/conv_result_collector.md
CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the result word width.
REQ-002 The block SHALL have parameter KERNEL_SIZE, default 5, giving the convolution window edge.
REQ-003 The block SHALL have parameter IMAGE_SIZE, default 28, giving the input image edge; OUT_SIZE = IMAGE_SIZE-KERNEL_SIZE+1, which is 24 at the defaults.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO entries, a power of two.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: begin-frame pulse.
REQ-008 The block SHALL have port in_valid, input, 1 bit: high in every cycle a pixel is presented to the convolver datapath.
REQ-009 The block SHALL have port result_in, input, DATA_WIDTH bits, signed: the convolver adder-tree result.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the FIFO head.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH bits, signed: the feature-map value.
REQ-013 The block SHALL have ports out_row and out_col, outputs, clog2(OUT_SIZE) bits each: the feature-map coordinates of out_data.
REQ-014 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-016 The block SHALL have ports overflow and stream_err, outputs, 1 bit each: sticky error flags.

Function
REQ-017 The FSM SHALL have states IDLE, STREAM, DRAIN and DONE.
REQ-018 In IDLE, start SHALL clear the pixel counters pix_row/pix_col, overflow and stream_err, and move to STREAM; start outside IDLE SHALL be ignored.
REQ-019 In STREAM, each in_valid cycle SHALL advance pix_col; pix_col SHALL wrap from IMAGE_SIZE-1 to 0 and increment pix_row.
REQ-020 The block SHALL register in_valid, pix_row and pix_col one cycle (valid_d); result_in SHALL be sampled at the edge where valid_d is high, so the window whose bottom-right pixel is the one presented in cycle t is sampled at the end of cycle t+1.
REQ-021 A sample SHALL be pushed only when the delayed row >= KERNEL_SIZE-1 and the delayed col >= KERNEL_SIZE-1, tagged out_row = row-(KERNEL_SIZE-1) and out_col = col-(KERNEL_SIZE-1); all other samples SHALL be discarded.
REQ-022 After the in_valid cycle carrying pixel (IMAGE_SIZE-1, IMAGE_SIZE-1), the FSM SHALL enter DRAIN.
REQ-023 DRAIN SHALL move to DONE once the final sample is pushed and the FIFO is empty.
REQ-024 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-025 If in_valid is low in any STREAM cycle, stream_err SHALL set and stay set, and the FSM SHALL return to IDLE without pushing further samples; the FIFO SHALL still drain normally.
REQ-026 The FIFO SHALL use a valid/ready handshake: the head pops on the edge where out_valid && out_ready are both high, and out_data/out_row/out_col SHALL hold stable while out_valid && !out_ready.
REQ-027 A push to a full FIFO SHALL succeed if a pop occurs in the same cycle; otherwise the sample SHALL be dropped and overflow SHALL set.
REQ-028 Push and pop on an empty FIFO in the same cycle SHALL write the entry, with out_valid rising in the next cycle; there is no fall-through.
REQ-029 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 Exactly OUT_SIZE*OUT_SIZE pushes SHALL be attempted per error-free frame, which is 576 at the defaults.

Reset
REQ-031 While reset is high, regardless of clk: the state SHALL be IDLE, all counters and FIFO pointers SHALL be 0, and out_valid, out_data, out_row, out_col, busy, done, overflow and stream_err SHALL all be 0.
REQ-032 Reset asserted mid-frame SHALL discard FIFO contents and the frame; a new start is required after release.

Configuration
REQ-033 With macro CONV_RESULT_RELU_EN defined, negative sampled values SHALL be replaced by 0 before the push.
REQ-034 Without CONV_RESULT_RELU_EN, values SHALL be pushed unmodified, two's complement.

Verification
REQ-035 Full frame: start, then 784 consecutive in_valid cycles with result_in = 16'h0100 and out_ready=1 -> 576 outputs of 16'h0100, first at (0,0) and last at (23,23), followed by one done pulse and no error flags.
REQ-036 Position tagging: result_in = pix_row*28+pix_col of the pixel presented the previous cycle -> the output at (r,c) equals (r+4)*28+(c+4); at (0,0) that is 116.
REQ-037 Backpressure: out_ready=0 throughout the frame -> 4 entries are held (0,0) to (0,3) and stay stable, overflow sets on the 5th push, and done is not asserted while the FIFO is non-empty.
REQ-038 Stream gap: in_valid dropped in pixel cycle 100 -> stream_err=1, the FSM returns to IDLE, and no pushes occur after the gap.
REQ-039 ReLU: result_in = 16'hFF00 (-1.0) at an accepted position -> out_data = 0 with CONV_RESULT_RELU_EN defined, and 16'hFF00 without it.
REQ-040 Reset at pixel 400 with 2 entries queued -> out_valid=0 immediately (asynchronous), busy=0, and a fresh frame afterwards completes with 576 outputs.
